// File: rtl/dram_ctl_pkg.sv
// ----------------------------------------------------------------------------
// dram_ctl_pkg: shared state encoding, defaults and CAS lane decode.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package dram_ctl_pkg;

  localparam int REFRESH_DIV_DEF  = 780;
  localparam int TRP_CYC_DEF      = 2;
  localparam int TRAS_REF_CYC_DEF = 4;

  localparam logic [3:0] CAS_NONE = 4'b1111;
  localparam logic [3:0] CAS_ALL  = 4'b0000;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ROW,
    ST_COL,
    ST_CAS,
    ST_ACK,
    ST_HOLD,
    ST_PRE,
    ST_RCAS,
    ST_RRAS
  } state_t;

  // 68030 dynamic bus sizing onto a 32-bit port; nCAS[3] carries offset 0
  function automatic logic [3:0] write_lanes(input logic [1:0] siz, input logic [1:0] a);
    logic [3:0] lanes;
    lanes = CAS_NONE;
    case ({siz, a})
      4'b01_00: lanes = 4'b0111;
      4'b01_01: lanes = 4'b1011;
      4'b01_10: lanes = 4'b1101;
      4'b01_11: lanes = 4'b1110;
      4'b10_00: lanes = 4'b0011;
      4'b10_01: lanes = 4'b1001;
      4'b10_10: lanes = 4'b1100;
      4'b10_11: lanes = 4'b1110;
      4'b11_00: lanes = 4'b0001;
      4'b11_01: lanes = 4'b1000;
      4'b11_10: lanes = 4'b1100;
      4'b11_11: lanes = 4'b1110;
      4'b00_00: lanes = 4'b0000;
      4'b00_01: lanes = 4'b1000;
      4'b00_10: lanes = 4'b1100;
      4'b00_11: lanes = 4'b1110;
      default:  lanes = CAS_NONE;
    endcase
    return lanes;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dram_refresh_timer.sv
// ----------------------------------------------------------------------------
// dram_refresh_timer: free-running refresh divider with a sticky request flag.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module dram_refresh_timer
  import dram_ctl_pkg::*;
#(
  parameter int REFRESH_DIV = REFRESH_DIV_DEF
) (
  input  logic DRAM_CLK,
  input  logic nRST,
  input  logic clr,
  output logic pending
);

  localparam int CW = $clog2(REFRESH_DIV);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend_q, pend_d;
  logic          tick;

  // A tick that lands while a request is already pending is simply absorbed
  always_comb begin
    tick   = (cnt_q == '0);
    cnt_d  = tick ? CW'(REFRESH_DIV - 1) : cnt_q - CW'(1);
    pend_d = pend_q;
    if (tick) pend_d = 1'b1;
    if (clr)  pend_d = 1'b0;
  end

  always_ff @(posedge DRAM_CLK or negedge nRST) begin
    if (!nRST) begin
      cnt_q  <= CW'(REFRESH_DIV - 1);
      pend_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
    end
  end

  assign pending = pend_q;

endmodule

`default_nettype wire

// File: rtl/dram_ctl.sv
// ----------------------------------------------------------------------------
// dram_ctl: FPM/EDO DRAM controller for one 32-bit SIMM bank with CBR refresh.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module dram_ctl
  import dram_ctl_pkg::*;
#(
  parameter int REFRESH_DIV  = REFRESH_DIV_DEF,
  parameter int TRP_CYC      = TRP_CYC_DEF,
  parameter int TRAS_REF_CYC = TRAS_REF_CYC_DEF
) (
  input  logic        DRAM_CLK,
  input  logic        nRST,
  input  logic        nDRAMSEL,
  input  logic        nAS,
  input  logic        nDS,
  input  logic        RnW,
  input  logic [1:0]  SIZ,
  input  logic [23:0] ADDR,
  output logic [10:0] MA,
  output logic        nRAS,
  output logic [3:0]  nCAS,
  output logic        nWE,
  output logic [1:0]  DSACK,
  output logic        REF_BUSY
);

  localparam int SW = 4;

  state_t        state_q, state_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic [10:0]   ma_q, ma_d;
  logic          ras_n_q, ras_n_d;
  logic [3:0]    cas_n_q, cas_n_d;
  logic          we_n_q, we_n_d;
  logic [1:0]    dsack_q, dsack_d;
  logic          busy_q, busy_d;
  logic          as_n_q, as_n_d;
  logic          ds_n_q, ds_n_d;
  logic          sel_q, sel_d;
  logic          ref_pending, ref_clr, go_pre;

  dram_refresh_timer #(.REFRESH_DIV(REFRESH_DIV)) u_timer (
    .DRAM_CLK (DRAM_CLK),
    .nRST     (nRST),
    .clr      (ref_clr),
    .pending  (ref_pending)
  );

  always_comb begin
    as_n_d  = nAS;
    ds_n_d  = nDS;
    sel_d   = ~nAS & ~nDRAMSEL;
    state_d = state_q;
    cnt_d   = cnt_q;
    ma_d    = ma_q;
    ras_n_d = ras_n_q;
    cas_n_d = cas_n_q;
    we_n_d  = we_n_q;
    dsack_d = dsack_q;
    busy_d  = busy_q;
    ref_clr = 1'b0;
    go_pre  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ref_pending) begin
          state_d = ST_RCAS;
          ref_clr = 1'b1;
          cas_n_d = CAS_ALL;
          we_n_d  = 1'b1;
          busy_d  = 1'b1;
        end else if (sel_q) begin
          state_d = ST_ROW;
          ras_n_d = 1'b0;
          ma_d    = ADDR[23:13];
          we_n_d  = RnW;
        end
      end
      ST_ROW: begin
        if (as_n_q) go_pre = 1'b1;
        else begin
          state_d = ST_COL;
          ma_d    = ADDR[12:2];
        end
      end
      // Writes hold off CAS until data is valid (nDS low)
      ST_COL: begin
        if (as_n_q) go_pre = 1'b1;
        else if (we_n_q || !ds_n_q) begin
          state_d = ST_CAS;
          cas_n_d = we_n_q ? CAS_ALL : write_lanes(SIZ, ADDR[1:0]);
        end
      end
      ST_CAS: begin
        if (as_n_q) go_pre = 1'b1;
        else begin
          state_d = ST_ACK;
          dsack_d = 2'b11;
        end
      end
      ST_ACK, ST_HOLD: begin
        if (as_n_q) go_pre = 1'b1;
        else        state_d = ST_HOLD;
      end
      ST_PRE: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - SW'(1);
      end
      ST_RCAS: begin
        state_d = ST_RRAS;
        ras_n_d = 1'b0;
        cnt_d   = SW'(TRAS_REF_CYC - 1);
      end
      ST_RRAS: begin
        if (cnt_q == '0) go_pre = 1'b1;
        else             cnt_d  = cnt_q - SW'(1);
      end
      default: state_d = ST_IDLE;
    endcase

    if (go_pre) begin
      state_d = ST_PRE;
      cnt_d   = SW'(TRP_CYC - 1);
      ras_n_d = 1'b1;
      cas_n_d = CAS_NONE;
      we_n_d  = 1'b1;
      dsack_d = 2'b00;
      busy_d  = 1'b0;
    end
  end

  always_ff @(posedge DRAM_CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ma_q    <= '0;
      ras_n_q <= 1'b1;
      cas_n_q <= CAS_NONE;
      we_n_q  <= 1'b1;
      dsack_q <= 2'b00;
      busy_q  <= 1'b0;
      as_n_q  <= 1'b1;
      ds_n_q  <= 1'b1;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ma_q    <= ma_d;
      ras_n_q <= ras_n_d;
      cas_n_q <= cas_n_d;
      we_n_q  <= we_n_d;
      dsack_q <= dsack_d;
      busy_q  <= busy_d;
      as_n_q  <= as_n_d;
      ds_n_q  <= ds_n_d;
      sel_q   <= sel_d;
    end
  end

  assign MA       = ma_q;
  assign nRAS     = ras_n_q;
  assign nCAS     = cas_n_q;
  assign nWE      = we_n_q;
  assign DSACK    = dsack_q;
  assign REF_BUSY = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_dram_ctl.sv
// ----------------------------------------------------------------------------
// tb_dram_ctl: directed + randomized self-checking bench for dram_ctl.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_dram_ctl;

  logic        DRAM_CLK = 1'b0;
  logic        nRST     = 1'b0;
  logic        nDRAMSEL = 1'b1;
  logic        nAS      = 1'b1;
  logic        nDS      = 1'b1;
  logic        RnW      = 1'b1;
  logic [1:0]  SIZ      = 2'b00;
  logic [23:0] ADDR     = '0;
  logic [10:0] MA;
  logic        nRAS;
  logic [3:0]  nCAS;
  logic        nWE;
  logic [1:0]  DSACK;
  logic        REF_BUSY;

  int checks = 0;
  int passed = 0;
  int edges  = 0;
  int refs   = 0;
  logic busy_prev = 1'b0;

  dram_ctl dut (
    .DRAM_CLK (DRAM_CLK),
    .nRST     (nRST),
    .nDRAMSEL (nDRAMSEL),
    .nAS      (nAS),
    .nDS      (nDS),
    .RnW      (RnW),
    .SIZ      (SIZ),
    .ADDR     (ADDR),
    .MA       (MA),
    .nRAS     (nRAS),
    .nCAS     (nCAS),
    .nWE      (nWE),
    .DSACK    (DSACK),
    .REF_BUSY (REF_BUSY)
  );

  always #10 DRAM_CLK = ~DRAM_CLK;

  // Count clock edges and refresh sequences since the last reset release
  always @(posedge DRAM_CLK or negedge nRST) begin
    if (!nRST) begin
      edges     = 0;
      refs      = 0;
      busy_prev = 1'b0;
    end else begin
      edges = edges + 1;
      if (REF_BUSY && !busy_prev) refs = refs + 1;
      busy_prev = REF_BUSY;
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Bytes written run from the offset up to the end of the port, capped by the size
  function automatic logic [3:0] model_lanes(input logic [1:0] siz, input logic [1:0] off);
    int nbytes;
    logic [3:0] m;
    nbytes = (siz == 2'b00) ? 4 : int'(siz);
    m = 4'b1111;
    for (int b = 0; b < 4; b++)
      if (b >= int'(off) && b < int'(off) + nbytes) m[3-b] = 1'b0;
    return m;
  endfunction

  task automatic release_bus();
    nAS = 1'b1; nDS = 1'b1; nDRAMSEL = 1'b1;
  endtask

  // mode 0: full cycle, 1: nAS negated while in COL, 2: stop once DSACK is seen
  task automatic do_access(input logic [23:0] a, input logic rnw, input logic [1:0] siz,
                           input int ds_dly, input int hold, input int mode);
    logic [3:0] mask;
    bit ok, bad;
    mask = rnw ? 4'b0000 : model_lanes(siz, a[1:0]);
    @(negedge DRAM_CLK);
    ADDR = a; RnW = rnw; SIZ = siz; nDRAMSEL = 1'b0; nAS = 1'b0;
    nDS = (rnw || ds_dly == 0) ? 1'b0 : 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(posedge DRAM_CLK); #1;
      if (nRAS === 1'b0 && REF_BUSY === 1'b0) ok = 1'b1;
    end
    chk("row_seen", 32'(ok), 32'd1);
    if (!ok) begin
      @(negedge DRAM_CLK); release_bus();
      return;
    end
    chk("row_ma", 32'(MA), 32'(a[23:13]));
    chk("row_we", 32'(nWE), 32'(rnw));
    chk("row_cas", 32'(nCAS), 32'hF);
    if (mode == 1) begin
      @(negedge DRAM_CLK); release_bus();
    end
    @(posedge DRAM_CLK); #1;
    chk("col_ma", 32'(MA), 32'(a[12:2]));
    chk("col_cas", 32'(nCAS), 32'hF);
    if (mode == 1) begin
      @(posedge DRAM_CLK); #1;
      chk("abort_ras", 32'(nRAS), 32'd1);
      chk("abort_cas", 32'(nCAS), 32'hF);
      bad = (DSACK !== 2'b00);
      repeat (3) begin
        @(posedge DRAM_CLK); #1;
        if (DSACK !== 2'b00) bad = 1'b1;
      end
      chk("abort_no_dsack", 32'(bad), 32'd0);
      return;
    end
    if (!rnw && ds_dly > 0) begin
      bad = 1'b0;
      repeat (ds_dly) begin
        @(posedge DRAM_CLK); #1;
        if (nCAS !== 4'hF) bad = 1'b1;
      end
      @(negedge DRAM_CLK); nDS = 1'b0;
      @(posedge DRAM_CLK); #1;
      if (nCAS !== 4'hF) bad = 1'b1;
      chk("col_wait_ds", 32'(bad), 32'd0);
    end
    @(posedge DRAM_CLK); #1;
    chk("cas_lanes", 32'(nCAS), 32'(mask));
    chk("cas_no_ack", 32'(DSACK), 32'd0);
    @(posedge DRAM_CLK); #1;
    chk("ack_dsack", 32'(DSACK), 32'h3);
    chk("ack_ras", 32'(nRAS), 32'd0);
    if (mode == 2) return;
    bad = 1'b0;
    repeat (hold) begin
      @(posedge DRAM_CLK); #1;
      if (DSACK !== 2'b11 || nCAS !== mask) bad = 1'b1;
    end
    @(negedge DRAM_CLK); release_bus();
    @(posedge DRAM_CLK); #1;
    if (DSACK !== 2'b11) bad = 1'b1;
    chk("hold_dsack", 32'(bad), 32'd0);
    @(posedge DRAM_CLK); #1;
    chk("pre_strobes", 32'({nRAS, nCAS, nWE, DSACK}), 32'({1'b1, 4'hF, 1'b1, 2'b00}));
    bad = 1'b0;
    repeat (2) begin
      @(posedge DRAM_CLK); #1;
      if (nRAS !== 1'b1) bad = 1'b1;
    end
    chk("pre_hold_ras", 32'(bad), 32'd0);
  endtask

  // After a reset release, check the first refresh arrives on the 781st edge
  task automatic first_refresh(input bit with_sel, input logic [23:0] a);
    bit early, bad;
    early = 1'b0;
    for (int k = 1; k <= 779; k++) begin
      @(posedge DRAM_CLK); #1;
      if (REF_BUSY !== 1'b0) early = 1'b1;
    end
    if (with_sel) begin
      @(negedge DRAM_CLK);
      ADDR = a; RnW = 1'b1; SIZ = 2'b00; nDRAMSEL = 1'b0; nAS = 1'b0; nDS = 1'b0;
    end
    @(posedge DRAM_CLK); #1;
    if (REF_BUSY !== 1'b0 || nRAS !== 1'b1) early = 1'b1;
    chk("ref_not_early", 32'(early), 32'd0);
    @(posedge DRAM_CLK); #1;
    chk("rcas_state", 32'({REF_BUSY, nRAS, nCAS, nWE}), 32'({1'b1, 1'b1, 4'h0, 1'b1}));
    bad = 1'b0;
    repeat (4) begin
      @(posedge DRAM_CLK); #1;
      if (nRAS !== 1'b0 || REF_BUSY !== 1'b1) bad = 1'b1;
    end
    chk("rras_len", 32'(bad), 32'd0);
    @(posedge DRAM_CLK); #1;
    chk("ref_pre", 32'({REF_BUSY, nRAS, nCAS}), 32'({1'b0, 1'b1, 4'hF}));
  endtask

  initial begin
    logic [23:0] ra;
    logic [1:0]  rs;
    logic        rw;
    bit ok;
    int ticks;

    // Reset state
    repeat (3) @(posedge DRAM_CLK);
    #1;
    chk("rst_outputs", 32'({MA, nRAS, nCAS, nWE, DSACK, REF_BUSY}),
        32'({11'd0, 1'b1, 4'hF, 1'b1, 2'b00, 1'b0}));
    @(negedge DRAM_CLK); nRST = 1'b1;
    first_refresh(1'b0, 24'h0);
    repeat (3) @(posedge DRAM_CLK);

    // Directed accesses
    do_access(24'h012344, 1'b1, 2'b00, 0, 1, 0);
    do_access(24'h000005, 1'b0, 2'b01, 3, 0, 0);
    do_access(24'h000002, 1'b0, 2'b10, 0, 2, 0);
    do_access(24'h000001, 1'b0, 2'b11, 0, 0, 0);
    do_access(24'h3ABCDE, 1'b1, 2'b00, 0, 0, 1);

    // Randomized accesses against the lane/address model
    for (int i = 0; i < 30; i++) begin
      ra = 24'($urandom);
      rs = 2'($urandom_range(0, 3));
      rw = 1'($urandom_range(0, 1));
      do_access(ra, rw, rs, $urandom_range(0, 3), $urandom_range(0, 3), 0);
      repeat ($urandom_range(0, 4)) @(posedge DRAM_CLK);
    end
    #1;
    ticks = edges / 780;
    ok = (refs == ticks) || (refs == ticks - 1);
    chk("refresh_count", 32'(ok), 32'd1);

    // Reset asserted mid-ACK negates strobes without a clock edge
    do_access(24'h00F00C, 1'b1, 2'b00, 0, 0, 2);
    #5 nRST = 1'b0;
    #1;
    chk("async_rst", 32'({MA, nRAS, nCAS, nWE, DSACK, REF_BUSY}),
        32'({11'd0, 1'b1, 4'hF, 1'b1, 2'b00, 1'b0}));
    release_bus();
    @(negedge DRAM_CLK);
    @(negedge DRAM_CLK); nRST = 1'b1;

    // Refresh tick and select on the same IDLE edge: refresh wins
    first_refresh(1'b1, 24'h012344);
    begin
      bit bad;
      bad = 1'b0;
      repeat (2) begin
        @(posedge DRAM_CLK); #1;
        if (nRAS !== 1'b1) bad = 1'b1;
      end
      chk("ref_then_pre", 32'(bad), 32'd0);
    end
    @(posedge DRAM_CLK); #1;
    chk("late_row_ras", 32'(nRAS), 32'd0);
    chk("late_row_ma", 32'(MA), 32'h009);
    @(posedge DRAM_CLK); #1;
    chk("late_col_ma", 32'(MA), 32'h0D1);
    @(posedge DRAM_CLK); #1;
    chk("late_cas", 32'(nCAS), 32'h0);
    @(posedge DRAM_CLK); #1;
    chk("late_ack", 32'(DSACK), 32'h3);
    @(negedge DRAM_CLK); release_bus();
    repeat (2) @(posedge DRAM_CLK);
    #1;
    chk("late_pre", 32'({nRAS, DSACK}), 32'({1'b1, 2'b00}));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
